// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// States plus the load-time pattern-length clamp.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } statetype;

  function automatic int clamp_len(input int len, input int max);
    if (len < 1) return 1;
    if (len > max) return max;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment yields one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAXV = '1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && q != MAXV) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control,
// registered match pulse and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ovl_in,
  input  logic               w,
  input  logic               w_valid,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic [1:0]         CurState
);

  statetype           state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, hist, hist_d, hist_nxt, mask;
  logic [LEN_W-1:0]   len_q, len_c, fill_cnt, fill_d, fill_inc;
  logic               ovl_q, hit, z_d, match;

  assign hist_nxt = {hist[MAX_LEN-2:0], w};
  assign fill_inc = fill_cnt + LEN_W'(1);
  assign len_c    = LEN_W'(clamp_len(int'(len_in), MAX_LEN));

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_q));
  end

  assign match = ((hist_nxt ^ pat_q) & mask) == '0;

  // Next-state, history and fill bookkeeping
  always_comb begin
    state_d = state_q;
    hist_d  = hist;
    fill_d  = fill_cnt;
    hit     = 1'b0;
    if (load) begin
      state_d = S_FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_FILL: if (w_valid) begin
          hist_d = hist_nxt;
          fill_d = fill_inc;
          if (fill_inc == len_q) begin
            hit     = match;
            state_d = S_RUN;
            if (match && !ovl_q) begin
              state_d = S_FILL;
              fill_d  = '0;
            end
          end
        end
        S_RUN: if (w_valid) begin
          hist_d = hist_nxt;
          hit    = match;
          if (match && !ovl_q) begin
            state_d = S_FILL;
            fill_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    z_d      = hit;
    armed    = (state_q != S_IDLE);
    CurState = state_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= LEN_W'(MAX_LEN);
      ovl_q    <= 1'b0;
      hist     <= '0;
      fill_cnt <= '0;
      z        <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist     <= hist_d;
      fill_cnt <= fill_d;
      z        <= z_d;
      if (load) begin
        pat_q <= pat_in;
        len_q <= len_c;
        ovl_q <= ovl_in;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (count_clr),
    .inc    (hit),
    .q      (match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog (CNT_W=2 to reach saturation).
// Driver queues expected pulses; negedge monitor pops and compares.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               Clock = 1'b0;
  logic               Resetn = 1'b0;
  logic               load = 1'b0;
  logic [MAX_LEN-1:0] pat_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic               ovl_in = 1'b0;
  logic               w = 1'b0;
  logic               w_valid = 1'b0;
  logic               count_clr = 1'b0;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic [1:0]         CurState;

  typedef struct {int idx; int cnt;} exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int drv_idx  = 0;
  int seen_idx = 0;
  int exp_cnt  = 0;

  always #5 Clock = ~Clock;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .load        (load),
    .pat_in      (pat_in),
    .len_in      (len_in),
    .ovl_in      (ovl_in),
    .w           (w),
    .w_valid     (w_valid),
    .count_clr   (count_clr),
    .z           (z),
    .match_count (match_count),
    .armed       (armed),
    .CurState    (CurState)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge Clock)
    if (w_valid) seen_idx <= drv_idx;

  always @(negedge Clock) begin
    if (Resetn && z) begin
      if (q.size() == 0) begin
        check("z_unexpected", int'(z), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("z_bit_index", seen_idx, e.idx);
        check("z_count", int'(match_count), e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p, input int len,
                         input logic o, input logic wv);
    pat_in  = p;
    len_in  = LEN_W'(len);
    ovl_in  = o;
    load    = 1'b1;
    w       = 1'b1;
    w_valid = wv;
    tick();
    load    = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic clear();
    count_clr = 1'b1;
    exp_cnt   = 0;
    tick();
    count_clr = 1'b0;
    check("clr_count", int'(match_count), 0);
  endtask

  task automatic send(input logic b, input logic e,
                      input logic clr, input int gap);
    exp_t x;
    w = b;
    w_valid = 1'b1;
    count_clr = clr;
    drv_idx++;
    if (clr) exp_cnt = 0;
    if (e) begin
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      x.idx = drv_idx;
      x.cnt = exp_cnt;
      q.push_back(x);
    end
    tick();
    w_valid = 1'b0;
    count_clr = 1'b0;
    repeat (gap) tick();
  endtask

  // bits/exps: MSB-first over n entries
  task automatic run_seq(input logic [31:0] bits, input logic [31:0] exps,
                         input int n, input int gap);
    for (int i = 0; i < n; i++)
      send(bits[n-1-i], exps[n-1-i], 1'b0, gap);
    tick();
    check("pending_pulses", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12 Resetn = 1'b1;
    tick();
    check("rst_z", int'(z), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_state", int'(CurState), 0);

    run_seq(32'h3FF, 32'h0, 10, 0);
    check("idle_count", int'(match_count), 0);
    check("idle_armed", int'(armed), 0);
    check("idle_state", int'(CurState), 0);

    do_load(8'b1101, 4, 1'b1, 1'b0);
    check("load_armed", int'(armed), 1);
    check("load_state", int'(CurState), 1);
    run_seq(32'b1101101, 32'b0001001, 7, 0);
    check("ovl_count", int'(match_count), 2);
    check("ovl_state", int'(CurState), 2);

    clear();
    do_load(8'b1101, 4, 1'b0, 1'b0);
    run_seq(32'b1101101, 32'b0001000, 7, 0);
    check("novl_count", int'(match_count), 1);
    check("novl_state", int'(CurState), 1);

    clear();
    do_load(8'b1111, 4, 1'b1, 1'b0);
    run_seq(32'b111111, 32'b000111, 6, 0);
    check("ones_ovl_count", int'(match_count), 3);
    run_seq(32'b11, 32'b11, 2, 0);
    check("sat_count", int'(match_count), 3);

    clear();
    do_load(8'b1111, 4, 1'b0, 1'b0);
    run_seq(32'hFF, 32'b00010001, 8, 2);
    check("ones_novl_gap_count", int'(match_count), 2);

    clear();
    do_load(8'b1101, 4, 1'b1, 1'b0);
    run_seq(32'b110, 32'b000, 3, 0);
    do_load(8'b01, 2, 1'b0, 1'b1);
    run_seq(32'b101, 32'b001, 3, 0);
    check("reload_count", int'(match_count), 1);

    do_load(8'h01, 0, 1'b1, 1'b0);
    run_seq(32'b101, 32'b101, 3, 0);
    check("len0_count", int'(match_count), 3);

    clear();
    do_load(8'hA5, 15, 1'b1, 1'b0);
    run_seq(32'hA5, 32'h01, 8, 0);
    check("lenmax_count", int'(match_count), 1);

    do_load(8'h01, 1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 0);
    send(1'b1, 1'b1, 1'b0, 0);
    send(1'b1, 1'b1, 1'b1, 0);
    tick();
    check("clr_with_match", int'(match_count), 1);
    check("pending_pulses", q.size(), 0);

    w = 1'b1;
    w_valid = 1'b1;
    drv_idx++;
    tick();
    w_valid = 1'b0;
    check("pre_reset_z", int'(z), 1);
    #1 Resetn = 1'b0;
    #1;
    check("async_rst_z", int'(z), 0);
    check("async_rst_count", int'(match_count), 0);
    check("async_rst_state", int'(CurState), 0);
    check("async_rst_armed", int'(armed), 0);
    #1 Resetn = 1'b1;
    tick();
    run_seq(32'h1F, 32'h0, 5, 0);
    check("post_rst_count", int'(match_count), 0);
    check("post_rst_armed", int'(armed), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
